mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 21 ++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus shared by the fetch and data ports.
// The arbiter drives the request side; the memory answers with ready/rdata.
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one memory port,
// with data priority, fetch-drop on redirect and a wait timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush_if,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    mem_port_arbiter_if.master mem,
    output logic [31:0] if_rdata,
    output logic [31:0] d_rdata,
    output logic        if_valid,
    output logic        d_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] LIM = (CW+1)'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IF   = 2'd1;
    localparam logic [1:0] S_D    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        wait_st, tmo, done;
    logic        d_pend, i_pend;
    logic        grant_d, grant_i;
    logic [31:0] rdata_w;

    // A port whose valid is pulsing still shows the completed request.
    assign d_pend  = d_req & ~d_valid_q;
    assign i_pend  = if_req & ~if_valid_q;
    assign wait_st = (state_q == S_IF) || (state_q == S_D);
    assign tmo     = (TIMEOUT_CYCLES != 0) && wait_st &&
                     !mem.mem_ready &&
                     (({1'b0, cnt_q} + 1'b1) == LIM);
    assign done    = wait_st && (mem.mem_ready || tmo);
    assign rdata_w = mem.mem_ready ? mem.mem_rdata : 32'h0;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = err_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        grant_d    = 1'b0;
        grant_i    = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d = d_pend;
                grant_i = ~d_pend & i_pend;
            end
            S_IF: begin
                if (flush_if) drop_d = 1'b1;
                if (done) begin
                    if (!(drop_q || flush_if)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rdata_w;
                    end
                    drop_d  = 1'b0;
                    grant_d = d_pend;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_D: begin
                if (done) begin
                    d_valid_d = 1'b1;
                    d_rdata_d = rdata_w;
                    grant_i   = i_pend;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo) err_d = 1'b1;
        if (done) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
        end

        if (grant_d) begin
            state_d = S_D;
            req_d   = 1'b1;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
            cnt_d   = '0;
        end else if (grant_i) begin
            state_d = S_IF;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = 32'h0;
            be_d    = 4'hF;
            cnt_d   = '0;
            drop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign if_valid      = if_valid_q;
    assign d_valid       = d_valid_q;
    assign stall_if      = if_req & ~if_valid_q;
    assign stall_mem     = d_req & ~d_valid_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES=4.
// Inputs and checks happen 1 time unit after each rising edge.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush_if, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata;
    logic        if_valid, d_valid, stall_if, stall_mem, bus_err;
    int          errors = 0;
    int          checks = 0;

    mem_port_arbiter_if mif();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be),
        .mem(mif),
        .if_rdata(if_rdata), .d_rdata(d_rdata),
        .if_valid(if_valid), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 0; flush_if = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mif.mem_ready = 0; mif.mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be} !== 6'h0 ||
            mif.mem_addr !== 0 || mif.mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_bus got req=%b we=%b be=%h addr=%h exp 0",
                     mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr);
        end
        checks++;
        if ({if_valid, d_valid, bus_err, stall_if, stall_mem} !== 5'h0 ||
            if_rdata !== 0 || d_rdata !== 0) begin
            errors++;
            $display("FAIL reset_out got iv=%b dv=%b err=%b ir=%h dr=%h exp 0",
                     if_valid, d_valid, bus_err, if_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h100;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++; $display("FAIL fetch_stall0 got=%b exp=1", stall_if);
        end
        tick();
        checks++;
        if (mif.mem_req !== 1 || mif.mem_addr !== 32'h100 ||
            mif.mem_be !== 4'hF || mif.mem_we !== 0) begin
            errors++;
            $display("FAIL fetch_grant got req=%b addr=%h be=%h we=%b exp 1/100/f/0",
                     mif.mem_req, mif.mem_addr, mif.mem_be, mif.mem_we);
        end
        checks++;
        if (stall_if !== 1 || if_valid !== 0) begin
            errors++;
            $display("FAIL fetch_stall1 got stall=%b valid=%b exp 1/0",
                     stall_if, if_valid);
        end
        mif.mem_ready = 1; mif.mem_rdata = 32'h93;
        tick();
        checks++;
        if (if_valid !== 1 || if_rdata !== 32'h93 ||
            mif.mem_req !== 0 || stall_if !== 0) begin
            errors++;
            $display("FAIL fetch_done got v=%b rd=%h req=%b stall=%b exp 1/93/0/0",
                     if_valid, if_rdata, mif.mem_req, stall_if);
        end
        if_req = 0; mif.mem_ready = 0;
        tick();
        checks++;
        if (if_valid !== 0 || if_rdata !== 32'h93 || mif.mem_req !== 0) begin
            errors++;
            $display("FAIL fetch_hold got v=%b rd=%h req=%b exp 0/93/0",
                     if_valid, if_rdata, mif.mem_req);
        end
    endtask

    task automatic test_contention();
        d_req = 1; d_we = 1; d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        if_req = 1; if_addr = 32'h300;
        tick();
        checks++;
        if (mif.mem_req !== 1 || mif.mem_we !== 1 || mif.mem_be !== 4'h3 ||
            mif.mem_addr !== 32'h2000 || mif.mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cont_dgrant got req=%b we=%b be=%h addr=%h wd=%h exp 1/1/3/2000/deadbeef",
                     mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata);
        end
        checks++;
        if (stall_mem !== 1 || stall_if !== 1) begin
            errors++;
            $display("FAIL cont_stall got sm=%b si=%b exp 1/1", stall_mem, stall_if);
        end
        mif.mem_ready = 1; mif.mem_rdata = 32'h0;
        tick();
        checks++;
        if (d_valid !== 1 || mif.mem_req !== 1 || mif.mem_addr !== 32'h300 ||
            mif.mem_we !== 0 || mif.mem_be !== 4'hF) begin
            errors++;
            $display("FAIL cont_igrant got dv=%b req=%b addr=%h we=%b be=%h exp 1/1/300/0/f",
                     d_valid, mif.mem_req, mif.mem_addr, mif.mem_we, mif.mem_be);
        end
        d_req = 0; d_we = 0; mif.mem_rdata = 32'h11;
        tick();
        checks++;
        if (if_valid !== 1 || if_rdata !== 32'h11 || mif.mem_req !== 0) begin
            errors++;
            $display("FAIL cont_idone got v=%b rd=%h req=%b exp 1/11/0",
                     if_valid, if_rdata, mif.mem_req);
        end
        if_req = 0; mif.mem_ready = 0;
        tick();
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h200;
        tick();
        flush_if = 1;
        tick();
        flush_if = 0;
        tick(); tick();
        mif.mem_ready = 1; mif.mem_rdata = 32'h13;
        if_addr = 32'h400;
        tick();
        checks++;
        if (if_valid !== 0 || if_rdata !== 32'h11 || mif.mem_req !== 0) begin
            errors++;
            $display("FAIL flush_drop got v=%b rd=%h req=%b exp 0/11/0",
                     if_valid, if_rdata, mif.mem_req);
        end
        mif.mem_ready = 0;
        tick();
        checks++;
        if (mif.mem_req !== 1 || mif.mem_addr !== 32'h400) begin
            errors++;
            $display("FAIL flush_regrant got req=%b addr=%h exp 1/400",
                     mif.mem_req, mif.mem_addr);
        end
        mif.mem_ready = 1; mif.mem_rdata = 32'h77;
        tick();
        checks++;
        if (if_valid !== 1 || if_rdata !== 32'h77) begin
            errors++;
            $display("FAIL flush_next got v=%b rd=%h exp 1/77", if_valid, if_rdata);
        end
        if_req = 0; mif.mem_ready = 0;
        tick();
    endtask

    task automatic test_alternate();
        int seq[4];
        int n = 0;
        d_req = 1; d_we = 0; d_addr = 32'h4000;
        if_req = 1; if_addr = 32'h500;
        mif.mem_ready = 1; mif.mem_rdata = 32'h5A5A;
        for (int c = 0; c < 30 && n < 4; c++) begin
            tick();
            if (d_valid === 1 && n < 4) begin seq[n] = 1; n++; end
            if (if_valid === 1 && n < 4) begin seq[n] = 0; n++; end
        end
        d_req = 0; if_req = 0;
        tick(); tick();
        mif.mem_ready = 0;
        tick();
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL alt_count got=%0d exp=4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (n == 4 && seq[k] !== ((k % 2 == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL alt_order[%0d] got d=%0d exp d=%0d",
                         k, seq[k], (k % 2 == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 32'h3000;
        tick();
        d_addr = 32'h3004; mif.mem_rdata = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d_valid !== 0 || mif.mem_addr !== 32'h3000 ||
                mif.mem_req !== 1 || stall_mem !== 1) begin
                errors++;
                $display("FAIL tmo_wait%0d got dv=%b addr=%h req=%b sm=%b exp 0/3000/1/1",
                         i, d_valid, mif.mem_addr, mif.mem_req, stall_mem);
            end
            tick();
        end
        checks++;
        if (d_valid !== 1 || d_rdata !== 0 || bus_err !== 1 ||
            mif.mem_req !== 0) begin
            errors++;
            $display("FAIL tmo_end got dv=%b dr=%h err=%b req=%b exp 1/0/1/0",
                     d_valid, d_rdata, bus_err, mif.mem_req);
        end
        d_req = 0;
        tick(); tick();
        checks++;
        if (bus_err !== 1 || d_valid !== 0) begin
            errors++;
            $display("FAIL tmo_sticky got err=%b dv=%b exp 1/0", bus_err, d_valid);
        end
    endtask

    task automatic test_limit_race();
        do_reset();
        checks++;
        if (bus_err !== 0) begin
            errors++; $display("FAIL race_errclr got=%b exp=0", bus_err);
        end
        d_req = 1; d_we = 0; d_addr = 32'h3100;
        tick();
        tick(); tick(); tick();
        mif.mem_ready = 1; mif.mem_rdata = 32'h55;
        tick();
        checks++;
        if (d_valid !== 1 || d_rdata !== 32'h55 || bus_err !== 0) begin
            errors++;
            $display("FAIL race_done got dv=%b dr=%h err=%b exp 1/55/0",
                     d_valid, d_rdata, bus_err);
        end
        d_req = 0; mif.mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_midop();
        d_req = 1; d_we = 1; d_addr = 32'h3200;
        d_wdata = 32'h1234; d_be = 4'h1;
        tick();
        checks++;
        if (mif.mem_req !== 1) begin
            errors++; $display("FAIL rmid_grant got=%b exp=1", mif.mem_req);
        end
        rst = 1;
        tick();
        checks++;
        if (mif.mem_req !== 0 || mif.mem_we !== 0 || mif.mem_addr !== 0 ||
            mif.mem_be !== 0 || d_rdata !== 0 || if_rdata !== 0 ||
            d_valid !== 0 || bus_err !== 0) begin
            errors++;
            $display("FAIL rmid_reset got req=%b we=%b addr=%h be=%h dr=%h ir=%h dv=%b exp all 0",
                     mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be,
                     d_rdata, if_rdata, d_valid);
        end
        rst = 0; d_req = 0; d_we = 0;
        mif.mem_ready = 1; mif.mem_rdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d_valid !== 0 || if_valid !== 0 || mif.mem_req !== 0) begin
                errors++;
                $display("FAIL rmid_novalid%0d got dv=%b iv=%b req=%b exp 0/0/0",
                         i, d_valid, if_valid, mif.mem_req);
            end
        end
        mif.mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_flush();
        test_alternate();
        test_timeout();
        test_limit_race();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
